// File: rtl/control_fsm.sv
// Multi-cycle control FSM for the 16-bit datapath: decodes opcodes into datapath selects/enables,
// sequences two-cycle loads, HALT, single-step debug mode and a saturating retired-instruction count.
module control_fsm #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       INST,
   input  logic             Zero,
   input  logic             step_mode,
   input  logic             step_req,
   output logic             PCSrc,
   output logic             RegSrc,
   output logic             RegWrEn,
   output logic             ALUSrc,
   output logic [2:0]       ALUopcode,
   output logic             DmemWrEn,
   output logic             WrSrc,
   output logic             PCEn,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] inst_count
);

   typedef enum logic [1:0] {EXEC, MEM, WAIT, HALT} state_t;

   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_AND  = 5'b00011;
   localparam logic [4:0] OP_OR   = 5'b00100;
   localparam logic [4:0] OP_SLT  = 5'b00101;
   localparam logic [4:0] OP_ADDI = 5'b01000;
   localparam logic [4:0] OP_LW   = 5'b01001;
   localparam logic [4:0] OP_SW   = 5'b01010;
   localparam logic [4:0] OP_BEQ  = 5'b01100;
   localparam logic [4:0] OP_BNE  = 5'b01101;
   localparam logic [4:0] OP_HALT = 5'b11111;

   state_t state, state_next, retire_next;
   logic   mark_illegal;

   // A retired instruction (PCEn=1) bumps the counter; the counter holds at all-ones.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= step_mode ? WAIT : EXEC;
         illegal    <= 1'b0;
         inst_count <= '0;
      end else begin
         state <= state_next;
         if (mark_illegal)
            illegal <= 1'b1;
         if (PCEn && (inst_count != '1))
            inst_count <= inst_count + CNT_W'(1);
      end
   end

   assign retire_next = step_mode ? WAIT : EXEC;
   assign halted      = (state == HALT);

   always_comb begin
      PCSrc        = 1'b0;
      RegSrc       = 1'b0;
      RegWrEn      = 1'b0;
      ALUSrc       = 1'b0;
      ALUopcode    = 3'b000;
      DmemWrEn     = 1'b0;
      WrSrc        = 1'b0;
      PCEn         = 1'b0;
      mark_illegal = 1'b0;
      state_next   = state;

      case (state)
         EXEC: begin
            state_next = retire_next;
            case (INST)
               OP_NOP: PCEn = 1'b1;
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                  RegSrc    = 1'b1;
                  ALUopcode = INST[2:0] - 3'd1;
                  RegWrEn   = 1'b1;
                  WrSrc     = 1'b1;
                  PCEn      = 1'b1;
               end
               OP_ADDI: begin
                  ALUSrc  = 1'b1;
                  RegWrEn = 1'b1;
                  WrSrc   = 1'b1;
                  PCEn    = 1'b1;
               end
               // Address phase only; the write-back and retire happen in MEM.
               OP_LW: begin
                  ALUSrc     = 1'b1;
                  state_next = MEM;
               end
               OP_SW: begin
                  ALUSrc   = 1'b1;
                  DmemWrEn = 1'b1;
                  PCEn     = 1'b1;
               end
               OP_BEQ, OP_BNE: begin
                  ALUopcode = 3'b001;
                  PCSrc     = INST[0] ? ~Zero : Zero;
                  PCEn      = 1'b1;
               end
               OP_HALT: state_next = HALT;
               default: begin
                  PCEn         = 1'b1;
                  mark_illegal = 1'b1;
               end
            endcase
         end
         MEM: begin
            ALUSrc     = 1'b1;
            RegWrEn    = 1'b1;
            PCEn       = 1'b1;
            state_next = retire_next;
         end
         WAIT: begin
            if (step_req || !step_mode)
               state_next = EXEC;
         end
         HALT: state_next = HALT;
         default: state_next = EXEC;
      endcase

      // Reset wins over everything, including a load caught in MEM.
      if (RST) begin
         PCSrc        = 1'b0;
         RegSrc       = 1'b0;
         RegWrEn      = 1'b0;
         ALUSrc       = 1'b0;
         ALUopcode    = 3'b000;
         DmemWrEn     = 1'b0;
         WrSrc        = 1'b0;
         PCEn         = 1'b0;
         mark_illegal = 1'b0;
      end
   end

endmodule
